// File: rtl/svf_mult_engine_if.sv
// Multiply handshake between an initiator (master) and the shared multiplier (slave).
// Handshake: initiator pulses start_i for one cycle with a_i/b_i valid on that edge; the
// responder raises ready_o for exactly one cycle when prod_o holds the new product.
interface svf_mult_engine_if #(
  parameter int A_W = 24,
  parameter int B_W = 16,
  parameter int P_W = 40
);
  logic           start_i;
  logic [A_W-1:0] a_i;
  logic [B_W-1:0] b_i;
  logic           busy_o;
  logic           ready_o;
  logic [P_W-1:0] prod_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, ready_o, prod_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, ready_o, prod_o
  );
endinterface

// File: rtl/svf_mult_engine.sv
// Shared radix-2 shift-add signed multiplier: one bit of B per cycle, fixed latency,
// product held in its own register between completions.
module svf_mult_engine #(
  parameter int A_W = 24,
  parameter int B_W = 16,
  parameter int P_W = 40
) (
  input  logic               clk_i,
  input  logic               rst_i,
  svf_mult_engine_if.slave   mul,
  output logic [1:0]         state_o
);

  localparam int CNT_W = $clog2(B_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]   a_sh_q, a_sh_d;
  logic [B_W-1:0]   b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   prod_q, prod_d;
  logic [P_W-1:0]   addend;
  logic             last;

  assign addend = b_sh_q[0] ? a_sh_q : '0;
  assign last   = (cnt_q == CNT_W'(B_W - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (mul.start_i) begin
          a_sh_d  = {{(P_W-A_W){mul.a_i[A_W-1]}}, mul.a_i};
          b_sh_d  = mul.b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // The MSB of B carries weight -2^(B_W-1), so its partial product is subtracted.
        acc_d  = last ? (acc_q - addend) : (acc_q + addend);
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        if (last) begin
          prod_d  = acc_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign mul.busy_o  = (state_q == CALC);
  assign mul.ready_o = (state_q == DONE);
  assign mul.prod_o  = prod_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_svf_mult_engine.sv
// Directed bench for svf_mult_engine: latency, signed products, hold, back-to-back and reset abort.
module tb_svf_mult_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state;
  int         checks = 0;
  int         failures = 0;

  svf_mult_engine_if #(.A_W(24), .B_W(16), .P_W(40)) mif ();

  svf_mult_engine #(.A_W(24), .B_W(16), .P_W(40)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .mul     (mif.slave),
    .state_o (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int a, input int b);
    mif.a_i     = a[23:0];
    mif.b_i     = b[15:0];
    mif.start_i = 1'b1;
    step();
    mif.start_i = 1'b0;
  endtask

  // Steps until ready_o, counting cycles from the start edge (cycle 1 follows it).
  task automatic wait_done(input int lat0, input logic [39:0] held, input bit chk_held,
                           output int lat, output int busy_cnt, output bit held_ok);
    lat = lat0;
    busy_cnt = 0;
    held_ok = 1'b1;
    while (mif.ready_o !== 1'b1 && lat < 60) begin
      if (mif.busy_o === 1'b1) busy_cnt++;
      if (chk_held && mif.prod_o !== held) held_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic run_mult(input string tag, input int a, input int b, input logic signed [39:0] exp);
    int lat, bc;
    bit hok;
    issue(a, b);
    wait_done(1, '0, 1'b0, lat, bc, hok);
    chk({tag, "_latency"}, 40'(lat), 40'd17);
    chk({tag, "_prod"}, mif.prod_o, exp);
  endtask

  initial begin
    int lat, bc, quiet;
    bit hok, seen;
    mif.start_i = 1'b0;
    mif.a_i = '0;
    mif.b_i = '0;
    repeat (3) step();
    chk("reset_busy", 40'(mif.busy_o), 40'd0);
    chk("reset_ready", 40'(mif.ready_o), 40'd0);
    chk("reset_prod", mif.prod_o, 40'd0);
    chk("reset_state", 40'(state), 40'd0);
    rst = 1'b0;
    step();

    // Basic: latency, busy duration, product, single-cycle ready.
    issue(1000, 3);
    wait_done(1, '0, 1'b0, lat, bc, hok);
    chk("basic_latency", 40'(lat), 40'd17);
    chk("basic_busy_cycles", 40'(bc), 40'd16);
    chk("basic_prod", mif.prod_o, 40'd3000);
    chk("basic_busy_at_ready", 40'(mif.busy_o), 40'd0);
    step();
    chk("basic_ready_pulse_end", 40'(mif.ready_o), 40'd0);
    chk("basic_back_idle", 40'(state), 40'd0);

    run_mult("neg_a", -5, 7, -40'sd35);
    run_mult("neg_b", 5, -7, -40'sd35);
    run_mult("neg_both", -5, -7, 40'sd35);
    run_mult("zero_a", 0, -32768, 40'sd0);
    run_mult("minus_one", -1, -1, 40'sd1);
    run_mult("ext_minmin", -8388608, -32768, 40'sd274877906944);
    run_mult("ext_maxmin", 8388607, -32768, -40'sd274877874176);
    run_mult("ext_maxmax", 8388607, 32767, 40'sd274869485569);

    run_mult("q15_half", 4096, 16384, 40'sd67108864);
    chk("q15_slice", 40'(mif.prod_o[38:15]), 40'd2048);
    step();
    step();
    chk("q15_hold", mif.prod_o, 40'd67108864);

    // Start pulsed mid-CALC must be ignored.
    issue(3, 4);
    repeat (4) step();
    mif.a_i = 24'd9;
    mif.b_i = 16'd9;
    mif.start_i = 1'b1;
    step();
    mif.start_i = 1'b0;
    wait_done(6, '0, 1'b0, lat, bc, hok);
    chk("ignore_latency", 40'(lat), 40'd17);
    chk("ignore_prod", mif.prod_o, 40'd12);

    // Back-to-back start in the DONE cycle; old product held throughout.
    issue(6, 7);
    wait_done(1, 40'd12, 1'b1, lat, bc, hok);
    chk("b2b_latency", 40'(lat), 40'd17);
    chk("b2b_held_old", 40'(hok), 40'd1);
    chk("b2b_prod", mif.prod_o, 40'd42);
    step();
    chk("b2b_ready_single", 40'(mif.ready_o), 40'd0);
    chk("b2b_idle", 40'(state), 40'd0);

    // Reset aborts an in-flight multiply.
    issue(100, 100);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 40'(mif.busy_o), 40'd0);
    chk("abort_prod", mif.prod_o, 40'd0);
    chk("abort_state", 40'(state), 40'd0);
    seen = 1'b0;
    for (quiet = 0; quiet < 30; quiet++) begin
      if (mif.ready_o === 1'b1) seen = 1'b1;
      step();
    end
    chk("abort_no_ready", 40'(seen), 40'd0);
    run_mult("after_abort", 2, 3, 40'sd6);

    // Reset and start on the same edge: reset wins.
    mif.a_i = 24'd5;
    mif.b_i = 16'd5;
    mif.start_i = 1'b1;
    rst = 1'b1;
    step();
    mif.start_i = 1'b0;
    rst = 1'b0;
    step();
    chk("rst_start_busy", 40'(mif.busy_o), 40'd0);
    chk("rst_start_state", 40'(state), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
